diff_freq_serial_in: RTL
========================

// Module: diff_freq_serial_in
// PURPOSE
//  Receive-side decoder for the differential-frequency serial link driven by diff_freq_serial_out.
//  - Measures the period between successive i_bit_tick strobes. Each period classifies one bit as
//    high speed (short period) or low speed (long period).
//  - Samples i_serial inside each bit to recover the output pattern.
//  - Returns {output pattern, frequency pattern} to the host as two bytes over the UART TX handshake.
// PARAMETERS
//  DATA_BIT     8     bits per frame (output pattern width = frequency pattern width)
//  TICK_10K_HZ  1000  clk cycles per low-speed bit (10 MHz clk)
//  TICK_20K_HZ  500   clk cycles per high-speed bit
//  TOL          50    allowed period deviation, in clk cycles
//  CNT_BIT      11    period counter width; must satisfy 2^CNT_BIT > 2*TICK_10K_HZ
// PORTS
//  clk            in   1         system clock
//  rst            in   1         synchronous, active-high reset
//  i_serial       in   1         serial data line
//  i_bit_tick     in   1         1-cycle strobe marking the start of each bit
//  i_done_tick    in   1         1-cycle strobe marking the end of the last bit
//  i_tx_done_tick in   1         UART TX byte-complete strobe
//  o_tx_start     out  1         1-cycle UART TX start strobe
//  o_tx_data      out  8         byte presented to UART TX; stable from o_tx_start until i_tx_done_tick
//  o_data         out  DATA_BIT  decoded output pattern, LSB = first bit
//  o_freq         out  DATA_BIT  decoded frequency pattern: 1 = HIGH_SPEED, 0 = LOW_SPEED
//  o_frame_tick   out  1         1-cycle strobe when o_data/o_freq update
//  o_err          out  1         1-cycle strobe when a frame is discarded
// BEHAVIOUR
//  Reset: every output is 0, state is IDLE, all counters are 0. Reset mid-frame or mid-send aborts
//   the operation with no further o_tx_start.
//  Derived constants:
//   - MIN_P = TICK_20K_HZ - TOL
//   - MAX_P = TICK_10K_HZ + TOL
//   - THRESH = (TICK_10K_HZ + TICK_20K_HZ) / 2
//   - SAMPLE = TICK_20K_HZ / 2
//   - TIMEOUT = 2 * TICK_10K_HZ
//  Counter: loaded to 1 on the edge that samples i_bit_tick, then increments by 1 per cycle.
//   The value seen with the next strobe equals the bit period N.
//  i_serial is captured when cnt == SAMPLE.
//  States:
//   - IDLE: wait for i_bit_tick, then bit_idx = 0 and go to MEASURE. i_done_tick is ignored here.
//   - MEASURE, on strobe (i_done_tick wins if both strobes occur in the same cycle):
//     - Close the current bit: data[bit_idx] = captured sample; freq[bit_idx] = (N < THRESH).
//     - N < MIN_P or N > MAX_P: error.
//     - i_bit_tick with bit_idx == DATA_BIT-1 (too many bits): error.
//     - Otherwise i_bit_tick: bit_idx++ and the counter restarts.
//     - i_done_tick with bit_idx == DATA_BIT-1 and no error: load o_data/o_freq, pulse o_frame_tick,
//       go to SEND_D.
//     - i_done_tick with bit_idx != DATA_BIT-1: error.
//     - cnt reaches TIMEOUT: error.
//     - Error: pulse o_err, go to IDLE, leave o_data/o_freq unchanged.
//   - SEND_D: pulse o_tx_start with o_tx_data = o_data, go to WAIT_D.
//   - WAIT_D: on i_tx_done_tick go to SEND_F.
//   - SEND_F: pulse o_tx_start with o_tx_data = o_freq, go to WAIT_F.
//   - WAIT_F: on i_tx_done_tick go to IDLE.
//   - No TX timeout; the block waits indefinitely in WAIT_D/WAIT_F.
//   - i_bit_tick and i_done_tick are ignored in SEND_D, WAIT_D, SEND_F and WAIT_F; that frame is lost.
//  Latency: o_frame_tick follows i_done_tick by 1 cycle; the first o_tx_start follows by 1 more.
//  Arithmetic: the counter saturates at TIMEOUT and never wraps. All compares are unsigned.
// STRUCTURE
//  Package diff_freq_pkg:
//   - state encoding
//   - LOW_SPEED = 0, HIGH_SPEED = 1
//   - derived constants MIN_P, MAX_P, THRESH, SAMPLE, TIMEOUT
//  Sub-module bit_period_meter:
//   - counter, sample capture, period classification and range check
//   - outputs: bit_val, bit_fast, period_bad, timeout
//  Top level: frame FSM, shift registers and the UART TX sequencer.
// TESTING
//  1. 8 ticks every 500 clk, i_serial = 0x55 LSB-first, done at 500
//     -> o_data = 0x55, o_freq = 0xFF, TX bytes 0x55 then 0xFF.
//  2. Data 0xA3; bits 0-3 at 500 clk, bits 4-7 at 1000 clk
//     -> o_freq = 0x0F, o_data = 0xA3, two o_tx_start pulses.
//  3. One bit period 749 -> that freq bit = 1; period 750 -> 0;
//     period 449 or 1051 -> o_err, no o_tx_start.
//  4. 7 bits then done -> o_err; 9th i_bit_tick -> o_err; no o_frame_tick in either case.
//  5. No strobe for 2000 clk after a tick -> o_err, back in IDLE;
//     a following valid frame decodes correctly.
//  6. rst asserted mid-MEASURE and again during WAIT_D -> all outputs 0 next cycle;
//     i_tx_done_tick delayed 5000 clk -> exactly one o_tx_start per byte.

Source files
------------

// File: rtl/diff_freq_serial_in_pkg.sv
// Shared types and derived timing constants for the differential-frequency serial receiver.
package diff_freq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    SEND_D,
    WAIT_D,
    SEND_F,
    WAIT_F
  } state_t;

  localparam logic LOW_SPEED  = 1'b0;
  localparam logic HIGH_SPEED = 1'b1;

  localparam int unsigned DEF_TICK_10K_HZ = 1000;
  localparam int unsigned DEF_TICK_20K_HZ = 500;
  localparam int unsigned DEF_TOL         = 50;

  function automatic int unsigned min_p(input int unsigned tick_20k, input int unsigned tol);
    return tick_20k - tol;
  endfunction

  function automatic int unsigned max_p(input int unsigned tick_10k, input int unsigned tol);
    return tick_10k + tol;
  endfunction

  function automatic int unsigned thresh(input int unsigned tick_10k, input int unsigned tick_20k);
    return (tick_10k + tick_20k) / 2;
  endfunction

  function automatic int unsigned sample_pt(input int unsigned tick_20k);
    return tick_20k / 2;
  endfunction

  function automatic int unsigned timeout_cnt(input int unsigned tick_10k);
    return 2 * tick_10k;
  endfunction

  localparam int unsigned MIN_P   = min_p(DEF_TICK_20K_HZ, DEF_TOL);
  localparam int unsigned MAX_P   = max_p(DEF_TICK_10K_HZ, DEF_TOL);
  localparam int unsigned THRESH  = thresh(DEF_TICK_10K_HZ, DEF_TICK_20K_HZ);
  localparam int unsigned SAMPLE  = sample_pt(DEF_TICK_20K_HZ);
  localparam int unsigned TIMEOUT = timeout_cnt(DEF_TICK_10K_HZ);

endpackage

// File: rtl/diff_freq_serial_in_if.sv
// UART TX byte handshake between the receiver and the host-side transmitter.
interface diff_freq_serial_in_if;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_done_tick;

  modport master (output o_tx_start, output o_tx_data, input i_tx_done_tick);
  modport slave  (input o_tx_start, input o_tx_data, output i_tx_done_tick);
endinterface

// File: rtl/diff_freq_serial_in_bit_period_meter.sv
// Bit period counter: restarts on each bit strobe, samples the line mid-bit and classifies the period.
module bit_period_meter
  import diff_freq_pkg::*;
#(
  parameter int unsigned TICK_10K_HZ = DEF_TICK_10K_HZ,
  parameter int unsigned TICK_20K_HZ = DEF_TICK_20K_HZ,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned CNT_BIT     = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  input  logic serial,
  output logic bit_val,
  output logic bit_fast,
  output logic period_bad,
  output logic timeout
);

  localparam logic [CNT_BIT-1:0] C_MIN     = CNT_BIT'(min_p(TICK_20K_HZ, TOL));
  localparam logic [CNT_BIT-1:0] C_MAX     = CNT_BIT'(max_p(TICK_10K_HZ, TOL));
  localparam logic [CNT_BIT-1:0] C_THRESH  = CNT_BIT'(thresh(TICK_10K_HZ, TICK_20K_HZ));
  localparam logic [CNT_BIT-1:0] C_SAMPLE  = CNT_BIT'(sample_pt(TICK_20K_HZ));
  localparam logic [CNT_BIT-1:0] C_TIMEOUT = CNT_BIT'(timeout_cnt(TICK_10K_HZ));

  logic [CNT_BIT-1:0] cnt;

  // Saturates at the timeout value so a stalled line can never wrap into a valid period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_val <= 1'b0;
    end else begin
      if (restart)
        cnt <= CNT_BIT'(1);
      else if (!run)
        cnt <= '0;
      else if (cnt != C_TIMEOUT)
        cnt <= cnt + 1'b1;
      if (cnt == C_SAMPLE)
        bit_val <= serial;
    end
  end

  assign bit_fast   = (cnt < C_THRESH);
  assign period_bad = (cnt < C_MIN) || (cnt > C_MAX);
  assign timeout    = run && (cnt == C_TIMEOUT);

endmodule

// File: rtl/diff_freq_serial_in.sv
// Frame decoder for the differential-frequency link: collects bits, then sends {data, freq} over UART TX.
module diff_freq_serial_in
  import diff_freq_pkg::*;
#(
  parameter int unsigned DATA_BIT    = 8,
  parameter int unsigned TICK_10K_HZ = DEF_TICK_10K_HZ,
  parameter int unsigned TICK_20K_HZ = DEF_TICK_20K_HZ,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned CNT_BIT     = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_serial,
  input  logic                  i_bit_tick,
  input  logic                  i_done_tick,
  diff_freq_serial_in_if.master tx,
  output logic [DATA_BIT-1:0]   o_data,
  output logic [DATA_BIT-1:0]   o_freq,
  output logic                  o_frame_tick,
  output logic                  o_err
);

  localparam int unsigned      IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DATA_BIT - 1);

  state_t             state;
  logic [IDX_W-1:0]   bit_idx;
  logic [DATA_BIT-1:0] data_sr, freq_sr, data_nxt, freq_nxt;
  logic               bit_val, bit_fast, period_bad, timeout;
  logic               run, restart, strobe, close_err;

  assign run    = (state == MEASURE);
  assign strobe = i_bit_tick || i_done_tick;
  // Done wins over a simultaneous bit tick; the bit count check flips with the strobe type.
  assign close_err = period_bad || (i_done_tick ? (bit_idx != LAST) : (bit_idx == LAST));
  assign restart   = i_bit_tick &&
                     ((state == IDLE) || (run && !i_done_tick && !close_err));

  bit_period_meter #(
    .TICK_10K_HZ (TICK_10K_HZ),
    .TICK_20K_HZ (TICK_20K_HZ),
    .TOL         (TOL),
    .CNT_BIT     (CNT_BIT)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .run        (run),
    .serial     (i_serial),
    .bit_val    (bit_val),
    .bit_fast   (bit_fast),
    .period_bad (period_bad),
    .timeout    (timeout)
  );

  always_comb begin
    data_nxt          = data_sr;
    freq_nxt          = freq_sr;
    data_nxt[bit_idx] = bit_val;
    freq_nxt[bit_idx] = bit_fast ? HIGH_SPEED : LOW_SPEED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_idx       <= '0;
      data_sr       <= '0;
      freq_sr       <= '0;
      o_data        <= '0;
      o_freq        <= '0;
      o_frame_tick  <= 1'b0;
      o_err         <= 1'b0;
      tx.o_tx_start <= 1'b0;
      tx.o_tx_data  <= '0;
    end else begin
      o_frame_tick  <= 1'b0;
      o_err         <= 1'b0;
      tx.o_tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_bit_tick) begin
            bit_idx <= '0;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (strobe) begin
            data_sr <= data_nxt;
            freq_sr <= freq_nxt;
            if (close_err) begin
              o_err <= 1'b1;
              state <= IDLE;
            end else if (i_done_tick) begin
              o_data       <= data_nxt;
              o_freq       <= freq_nxt;
              o_frame_tick <= 1'b1;
              state        <= SEND_D;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else if (timeout) begin
            o_err <= 1'b1;
            state <= IDLE;
          end
        end
        SEND_D: begin
          tx.o_tx_start <= 1'b1;
          tx.o_tx_data  <= 8'(o_data);
          state         <= WAIT_D;
        end
        WAIT_D: begin
          if (tx.i_tx_done_tick)
            state <= SEND_F;
        end
        SEND_F: begin
          tx.o_tx_start <= 1'b1;
          tx.o_tx_data  <= 8'(o_freq);
          state         <= WAIT_F;
        end
        WAIT_F: begin
          if (tx.i_tx_done_tick)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
